// File: rtl/adc_pack_pkg.sv
// Shared definitions for the ADC sample packer: FSM states, valid-count
// codes and the packed FIFO word layout.
package adc_pack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_FLUSH,
      ST_DONE
   } state_t;

   localparam logic [1:0] VC_1 = 2'b01;
   localparam logic [1:0] VC_2 = 2'b10;
   localparam logic [1:0] VC_3 = 2'b11;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned SAMPLE_W = 10;
   localparam int unsigned VC_LSB   = 30;
   localparam int unsigned OLD_LSB  = 20;
   localparam int unsigned MID_LSB  = 10;
   localparam int unsigned NEW_LSB  = 0;

   function automatic logic [WORD_W-1:0] pack_word(
      input logic [1:0]          vc,
      input logic [SAMPLE_W-1:0] s_old,
      input logic [SAMPLE_W-1:0] s_mid,
      input logic [SAMPLE_W-1:0] s_new
   );
      logic [WORD_W-1:0] w;
      w = '0;
      w[VC_LSB  +: 2]        = vc;
      w[OLD_LSB +: SAMPLE_W] = s_old;
      w[MID_LSB +: SAMPLE_W] = s_mid;
      w[NEW_LSB +: SAMPLE_W] = s_new;
      return w;
   endfunction

endpackage

// File: rtl/adc_sample_packer_if.sv
// Write-side handshake between the sample packer and its downstream FIFO.
interface adc_sample_packer_if;
   import adc_pack_pkg::*;

   logic [WORD_W-1:0] fifo_din_o;
   logic              fifo_wr_o;
   logic              fifo_full_i;

   modport master (output fifo_din_o, output fifo_wr_o, input  fifo_full_i);
   modport slave  (input  fifo_din_o, input  fifo_wr_o, output fifo_full_i);

endinterface

// File: rtl/adc_sample_packer.sv
// Packs 10-bit ADC samples three per 32-bit FIFO word during a triggered
// capture, with a sample limit, partial-word flush and sticky status flags.
module adc_sample_packer
   import adc_pack_pkg::*;
#(
   parameter logic [31:0] MAX_DEFAULT = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [SAMPLE_W-1:0]       adc_data_i,
   input  logic                      adc_or_i,
   input  logic                      capture_go_i,
   input  logic [31:0]               max_samples_i,
   adc_sample_packer_if.master       fifo,
   output logic                      capture_done_o,
   output logic [31:0]               samples_o,
   output logic                      overflow_o,
   output logic                      or_seen_o
);

   state_t              state_q, state_n;
   logic [1:0]          slot_cnt_q, slot_cnt_n;
   logic [SAMPLE_W-1:0] slot0_q, slot0_n;
   logic [SAMPLE_W-1:0] slot1_q, slot1_n;
   logic [WORD_W-1:0]   word_q, word_n;
   logic [WORD_W-1:0]   din_last_q;
   logic                wr_pend_q;
   logic                load_word;
   logic                accept;
   logic                clear;
   logic                limit_hit;
   logic [31:0]         eff_limit;
   logic                wr_fire;

   assign eff_limit = (max_samples_i != '0) ? max_samples_i : MAX_DEFAULT;
   assign limit_hit = (eff_limit != '0) && (samples_q_ne_max()) &&
                      ((samples_o + 32'd1) == eff_limit);

   function automatic logic samples_q_ne_max();
      return samples_o != '1;
   endfunction

   // A word is presented one cycle after it is formed; FIFO full is judged
   // in that write cycle, so the strobe is gated combinationally.
   assign wr_fire         = wr_pend_q & ~fifo.fifo_full_i & ~reset;
   assign fifo.fifo_wr_o  = wr_fire;
   assign fifo.fifo_din_o = wr_fire ? word_q : din_last_q;

   always_comb begin
      state_n    = state_q;
      slot_cnt_n = slot_cnt_q;
      slot0_n    = slot0_q;
      slot1_n    = slot1_q;
      word_n     = word_q;
      load_word  = 1'b0;
      accept     = 1'b0;
      clear      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (capture_go_i) begin
               state_n    = ST_CAPTURE;
               clear      = 1'b1;
               slot_cnt_n = '0;
            end
         end
         ST_CAPTURE: begin
            if (!capture_go_i) begin
               state_n = ST_FLUSH;
            end else begin
               accept = 1'b1;
               unique case (slot_cnt_q)
                  2'd0: begin
                     slot0_n    = adc_data_i;
                     slot_cnt_n = 2'd1;
                  end
                  2'd1: begin
                     slot1_n    = adc_data_i;
                     slot_cnt_n = 2'd2;
                  end
                  default: begin
                     slot_cnt_n = 2'd0;
                     load_word  = 1'b1;
                     word_n     = pack_word(VC_3, slot0_q, slot1_q, adc_data_i);
                  end
               endcase
               if (limit_hit) state_n = ST_FLUSH;
            end
            // The partial word is formed on entry so it is written during
            // FLUSH; a full word and a partial word can never coincide.
            if (state_n == ST_FLUSH && slot_cnt_n != 2'd0) begin
               load_word = 1'b1;
               word_n    = (slot_cnt_n == 2'd1)
                         ? pack_word(VC_1, slot0_n, '0, '0)
                         : pack_word(VC_2, slot0_n, slot1_n, '0);
            end
         end
         ST_FLUSH: begin
            slot_cnt_n = '0;
            state_n    = ST_DONE;
         end
         ST_DONE: begin
            if (!capture_go_i) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         slot_cnt_q     <= '0;
         slot0_q        <= '0;
         slot1_q        <= '0;
         word_q         <= '0;
         din_last_q     <= '0;
         wr_pend_q      <= 1'b0;
         capture_done_o <= 1'b0;
         samples_o      <= '0;
         overflow_o     <= 1'b0;
         or_seen_o      <= 1'b0;
      end else begin
         state_q        <= state_n;
         slot_cnt_q     <= slot_cnt_n;
         slot0_q        <= slot0_n;
         slot1_q        <= slot1_n;
         wr_pend_q      <= load_word;
         capture_done_o <= (state_n == ST_DONE);
         if (load_word) word_q <= word_n;
         if (wr_fire)   din_last_q <= word_q;
         if (clear) begin
            samples_o  <= '0;
            overflow_o <= 1'b0;
            or_seen_o  <= 1'b0;
         end else begin
            if (accept && samples_o != '1) samples_o <= samples_o + 32'd1;
            if (accept && adc_or_i)         or_seen_o <= 1'b1;
            if (wr_pend_q && fifo.fifo_full_i) overflow_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_sample_packer.sv
// Randomized bench for adc_sample_packer: each capture's write schedule and
// status flags are predicted from the sample-grouping rules and compared per cycle.
module tb_adc_sample_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  adc_data;
   logic        adc_or;
   logic        capture_go;
   logic [31:0] max_samples;
   logic        capture_done;
   logic [31:0] samples;
   logic        overflow;
   logic        or_seen;

   adc_sample_packer_if fifo_if ();

   adc_sample_packer #(.MAX_DEFAULT(32'd0)) dut (
      .clk            (clk),
      .reset          (reset),
      .adc_data_i     (adc_data),
      .adc_or_i       (adc_or),
      .capture_go_i   (capture_go),
      .max_samples_i  (max_samples),
      .fifo           (fifo_if),
      .capture_done_o (capture_done),
      .samples_o      (samples),
      .overflow_o     (overflow),
      .or_seen_o      (or_seen)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [31:0] last_din;
   logic [31:0] prev_samples;
   logic        prev_ovf;
   logic        prev_or;
   logic [31:0] wr_log[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // g: capture cycle where go drops; lim: max_samples_i; base<0 = random data;
   // full_mode 0 never, 1 random, 2 window [fa,fb]; or_idx -2 random, -1 none.
   task automatic run_capture(input int g, input int lim, input int base,
                              input int full_mode, input int fa, input int fb,
                              input int or_idx);
      logic [9:0]  dat[64];
      bit          orf[64];
      bit          fl[64];
      logic [31:0] sw[64];
      bit          sv[64];
      bit          hit, ovf_run, or_exp, exp_wr, exp_done;
      int          n_acc, flush, done_end, acc_before;
      for (int k = 0; k < 64; k++) begin
         dat[k] = (base >= 0) ? 10'(base + k) : 10'($urandom);
         orf[k] = (or_idx == -2) ? ($urandom_range(0, 5) == 0) : (k == or_idx);
         fl[k]  = (full_mode == 1) ? ($urandom_range(0, 2) == 0)
                                   : (full_mode == 2 && k >= fa && k <= fb);
         sv[k]  = 1'b0;
         sw[k]  = '0;
      end
      hit      = (lim != 0) && (lim <= g);
      n_acc    = hit ? lim : g;
      flush    = hit ? lim : g + 1;
      done_end = (g > flush + 1) ? g : flush + 1;
      for (int j = 0; j < n_acc / 3; j++) begin
         sv[3*j+3] = 1'b1;
         sw[3*j+3] = {2'b11, dat[3*j], dat[3*j+1], dat[3*j+2]};
      end
      if (n_acc % 3 == 1) begin
         sv[flush] = 1'b1;
         sw[flush] = {2'b01, dat[n_acc-1], 20'd0};
      end else if (n_acc % 3 == 2) begin
         sv[flush] = 1'b1;
         sw[flush] = {2'b10, dat[n_acc-2], dat[n_acc-1], 10'd0};
      end

      // IDLE cycle where go is first seen: nothing accepted, old status held
      @(negedge clk);
      capture_go       = 1'b1;
      max_samples      = 32'(lim);
      adc_data         = 10'($urandom);
      adc_or           = 1'b1;
      fifo_if.fifo_full_i = 1'($urandom);
      #1;
      check_val("idle_wr", 32'(fifo_if.fifo_wr_o), 32'd0);
      check_val("idle_din", fifo_if.fifo_din_o, last_din);
      check_val("idle_samples", samples, prev_samples);
      check_val("idle_ovf", 32'(overflow), 32'(prev_ovf));
      check_val("idle_or", 32'(or_seen), 32'(prev_or));
      check_val("idle_done", 32'(capture_done), 32'd0);

      ovf_run = 1'b0;
      for (int k = 0; k <= done_end + 2; k++) begin
         @(negedge clk);
         adc_data            = dat[k];
         adc_or              = orf[k];
         capture_go          = (k < g);
         fifo_if.fifo_full_i = fl[k];
         #1;
         acc_before = (k < n_acc) ? k : n_acc;
         or_exp = 1'b0;
         for (int i = 0; i < acc_before; i++) or_exp |= orf[i];
         exp_wr   = sv[k] && !fl[k];
         exp_done = (k >= flush + 1) && (k <= done_end);
         check_val("wr", 32'(fifo_if.fifo_wr_o), 32'(exp_wr));
         if (exp_wr) begin
            check_val("din_word", fifo_if.fifo_din_o, sw[k]);
            last_din = sw[k];
            wr_log.push_back(fifo_if.fifo_din_o);
         end else begin
            check_val("din_hold", fifo_if.fifo_din_o, last_din);
         end
         check_val("samples", samples, 32'(acc_before));
         check_val("or_seen", 32'(or_seen), 32'(or_exp));
         check_val("overflow", 32'(overflow), 32'(ovf_run));
         check_val("done", 32'(capture_done), 32'(exp_done));
         if (sv[k] && fl[k]) ovf_run = 1'b1;
      end
      prev_samples = 32'(n_acc);
      prev_ovf     = ovf_run;
      or_exp = 1'b0;
      for (int i = 0; i < n_acc; i++) or_exp |= orf[i];
      prev_or = or_exp;
      fifo_if.fifo_full_i = 1'b0;
   endtask

   initial begin
      reset               = 1'b1;
      capture_go          = 1'b0;
      adc_data            = '0;
      adc_or              = 1'b0;
      max_samples         = '0;
      fifo_if.fifo_full_i = 1'b0;
      last_din            = '0;
      prev_samples        = '0;
      prev_ovf            = 1'b0;
      prev_or             = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_wr", 32'(fifo_if.fifo_wr_o), 32'd0);
      check_val("rst_din", fifo_if.fifo_din_o, 32'd0);
      check_val("rst_done", 32'(capture_done), 32'd0);
      check_val("rst_samples", samples, 32'd0);
      check_val("rst_ovf", 32'(overflow), 32'd0);
      check_val("rst_or", 32'(or_seen), 32'd0);
      reset = 1'b0;

      // limit 6, ramp 0..5
      wr_log.delete();
      run_capture(8, 6, 0, 0, 0, 0, -1);
      check_val("lim6_nwr", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() == 2) begin
         check_val("lim6_w0", wr_log[0], 32'hC000_0402);
         check_val("lim6_w1", wr_log[1], 32'hC030_1005);
      end
      check_val("lim6_samples", samples, 32'd6);

      // limit 4, ramp 10..13: full word then VC_1 partial
      wr_log.delete();
      run_capture(8, 4, 10, 0, 0, 0, -1);
      check_val("lim4_nwr", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() == 2) begin
         check_val("lim4_w0", wr_log[0], 32'hC0A0_2C0C);
         check_val("lim4_w1", wr_log[1], 32'h40D0_0000);
      end

      // unlimited, go dropped after 5 samples: partial with VC_2
      wr_log.delete();
      run_capture(5, 0, 20, 0, 0, 0, -1);
      check_val("go5_nwr", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() == 2) check_val("go5_vc", 32'(wr_log[1][31:30]), 32'd2);

      // FIFO full around the second word's write
      wr_log.delete();
      run_capture(12, 0, 30, 2, 5, 6, -1);
      check_val("full_nwr", 32'(wr_log.size()), 32'd3);
      check_val("ovf_sticky", 32'(overflow), 32'd1);

      // reset after two samples aborts the capture
      @(negedge clk);
      capture_go = 1'b1;
      max_samples = '0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         adc_data = 10'(k + 7);
         adc_or   = 1'b1;
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("abort_wr", 32'(fifo_if.fifo_wr_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      capture_go = 1'b0;
      #1;
      check_val("abort_samples", samples, 32'd0);
      check_val("abort_or", 32'(or_seen), 32'd0);
      check_val("abort_ovf", 32'(overflow), 32'd0);
      check_val("abort_done", 32'(capture_done), 32'd0);
      check_val("abort_din", fifo_if.fifo_din_o, 32'd0);
      last_din = '0; prev_samples = '0; prev_ovf = 1'b0; prev_or = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         check_val("post_rst_idle", samples, 32'd0);
         check_val("post_rst_wr", 32'(fifo_if.fifo_wr_o), 32'd0);
      end
      wr_log.delete();
      run_capture(3, 0, 100, 0, 0, 0, -1);
      check_val("after_rst_nwr", 32'(wr_log.size()), 32'd1);

      // out-of-range only on the sample past the limit, then on index 2
      run_capture(8, 4, 0, 0, 0, 0, 4);
      check_val("or_past_limit", 32'(or_seen), 32'd0);
      run_capture(6, 0, 0, 0, 0, 0, 2);
      check_val("or_idx2", 32'(or_seen), 32'd1);

      for (int t = 0; t < 25; t++) begin
         int g;
         int lim;
         g   = int'($urandom_range(0, 30));
         lim = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 32));
         run_capture(g, lim, -1, 1, 0, 0, -2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_sample_packer.md
ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

Interface
REQ-001 Parameter MAX_DEFAULT, default 0: max sample limit used when max_samples_i is 0; 0 means unlimited.
REQ-002 clk  in  1  ADC sample clock; the block's only clock; all logic on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 adc_data_i  in  10  registered ADC sample, one per clk.
REQ-005 adc_or_i  in  1  ADC out-of-range flag, aligned with adc_data_i.
REQ-006 capture_go_i  in  1  level from trigger unit; high = capture in progress.
REQ-007 max_samples_i  in  32  sample limit; 0 selects MAX_DEFAULT.
REQ-008 fifo_full_i  in  1  downstream FIFO full.
REQ-009 fifo_din_o  out  32  packed word to FIFO.
REQ-010 fifo_wr_o  out  1  one-cycle write strobe for fifo_din_o.
REQ-011 capture_done_o  out  1  capture finished; feeds the trigger unit's capture_done input.
REQ-012 samples_o  out  32  samples accepted in the current or last capture.
REQ-013 overflow_o  out  1  sticky; a word was dropped because of FIFO full.
REQ-014 or_seen_o  out  1  sticky; adc_or_i was high on an accepted sample.

Function
REQ-015 Word format: [31:30] = valid count (2'b11 = 3 samples; 2'b01 = 1 sample; 2'b10 = 2 samples); [29:20] = oldest sample; [19:10] = middle sample; [9:0] = newest sample; unused slots are zero.
REQ-016 FSM states: IDLE, CAPTURE, FLUSH, DONE.
REQ-017 IDLE -> CAPTURE when capture_go_i = 1. On the transition, clear samples_o, overflow_o, or_seen_o, and the slot counter.
REQ-018 In CAPTURE, accept adc_data_i on every clk. Fill slots oldest-first and increment samples_o by 1 per accepted sample.
REQ-019 When the third slot fills on cycle N, drive fifo_wr_o = 1 with the full word at cycle N+1; the slot counter wraps to 0 with no lost cycle.
REQ-020 Define effective limit L as max_samples_i if it is nonzero, otherwise MAX_DEFAULT. If L != 0 and the sample accepted on cycle N is number L, go to FLUSH at N+1; no further samples are accepted.
REQ-021 If capture_go_i = 0 in CAPTURE, go to FLUSH and do not accept the sample on that cycle.
REQ-022 FLUSH, one cycle: if the slot counter is nonzero, write the partial word with its valid count; otherwise no write. Then go to DONE.
REQ-023 If a full-word write (REQ-019) falls on the FLUSH cycle, write the full word. The partial flush then occurs only if slots remain, and no write is lost.
REQ-024 DONE: capture_done_o = 1, registered. DONE -> IDLE when capture_go_i = 0; capture_done_o drops in the same transition.
REQ-025 A write attempted while fifo_full_i = 1 is dropped: fifo_wr_o stays 0 and overflow_o is set. Capture continues.
REQ-026 samples_o saturates at 32'hFFFFFFFF; the slot counter still wraps.
REQ-027 or_seen_o is set only by samples that are accepted.
REQ-028 fifo_din_o holds its last value when fifo_wr_o = 0.

Reset
REQ-029 While reset = 1: state IDLE, all outputs 0, slots and counters 0.
REQ-030 Reset during CAPTURE or FLUSH aborts with no flush write. After reset falls, a new capture starts only when capture_go_i = 1 is seen in IDLE.

Structure
REQ-031 Shared package adc_pack_pkg holds the FSM state encoding, the valid-count encodings (VC_1, VC_2, VC_3), and the word field bit positions.
REQ-032 No sub-module: the FSM, slot register, and counters live in one module of 120-400 RTL lines.

Verification
REQ-033 max_samples_i = 6, ramp 0..5, FIFO never full -> two writes: 32'hC0000000|(0<<20)|(1<<10)|2 and 32'hC0000000|(3<<20)|(4<<10)|5; capture_done_o = 1 two cycles after the sixth sample; samples_o = 6.
REQ-034 max_samples_i = 4, ramp 10..13 -> full word {11,10,11,12}, then at FLUSH the partial word {01,13,0,0}; samples_o = 4.
REQ-035 max_samples_i = 0, MAX_DEFAULT = 0, capture_go_i dropped after 5 samples -> one full word plus a partial word with valid count 2'b10.
REQ-036 fifo_full_i = 1 during the second word write -> that word is absent, overflow_o = 1 until the next capture start, and the third word is written normally.
REQ-037 reset pulsed after 2 samples -> no write, all outputs 0; a subsequent capture with 3 samples gives one full word.
REQ-038 adc_or_i = 1 only on the sample that follows the limit -> or_seen_o stays 0; adc_or_i = 1 on the sample at index 2 -> or_seen_o = 1.
